friscv_rv32i_dbus_bridge: RTL and testbench
===========================================

// Module: friscv_rv32i_dbus_bridge
// PURPOSE
//  Converts the ALU data-memory request port (mem_en/wr/addr/wdata/strb, rdata/ready) into an AXI4-lite master.
//  Sits directly downstream of the RV32I ALU's memory interface; one transaction outstanding at a time.
//  Registers the request on acceptance, runs read or write channel handshakes, returns a 1-cycle completion.
// PARAMETERS
//  ADDRW  16  address width, core side and AXI side
//  XLEN   32  data width; strobe width is XLEN/8
// PORTS
//  aclk       in   1        clock
//  aresetn    in   1        asynchronous active-low reset
//  srst       in   1        synchronous active-high reset, same effect as aresetn
//  mem_en     in   1        core request valid, held until mem_ready
//  mem_wr     in   1        1=write, 0=read
//  mem_addr   in   ADDRW    byte address
//  mem_wdata  in   XLEN     write data
//  mem_strb   in   XLEN/8   write byte enables
//  mem_rdata  out  XLEN     read data, valid when mem_ready & read
//  mem_ready  out  1        completion pulse, 1 cycle
//  mem_err    out  1        qualifies mem_ready: response != OKAY
//  awvalid/awready out/in 1; awaddr out ADDRW; awprot out 3 (=3'b000)
//  wvalid/wready   out/in 1; wdata out XLEN; wstrb out XLEN/8
//  bvalid/bready   in/out 1; bresp in 2
//  arvalid/arready out/in 1; araddr out ADDRW; arprot out 3 (=3'b000)
//  rvalid/rready   in/out 1; rdata in XLEN; rresp in 2
// BEHAVIOUR
//  Reset (aresetn low or srst): state=IDLE; all valid/ready outputs, mem_ready, mem_err = 0; mem_rdata = 0.
//  FSM: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
//  IDLE: mem_en sampled; addr/wdata/strb/wr registered.
//    Next state: RD_ADDR if !mem_wr, WR_REQ if mem_wr.
//  RD_ADDR: arvalid=1 until arready -> RD_DATA.
//  RD_DATA: rready=1; on rvalid -> capture rdata into mem_rdata, err=(rresp!=2'b00) -> DONE.
//  WR_REQ: awvalid and wvalid asserted together. Each drops independently after its handshake (aw_done, w_done flags).
//    Exit to WR_RESP in the cycle the last one completes; simultaneous completion allowed.
//  WR_RESP: bready=1; on bvalid -> err=(bresp!=2'b00) -> DONE.
//  DONE: mem_ready=1, mem_err=latched err for exactly one cycle -> IDLE.
//  mem_rdata holds its value until the next read completes; writes leave it unchanged.
//  Request fields are latched at acceptance; core changes while busy are ignored.
//  mem_en still high in the cycle after DONE is a new request (back-to-back; 1 IDLE cycle between).
//  Valids never drop before handshake (AXI rule); addr/data stable while valid.
//  Zero-wait slave latency from acceptance cycle N:
//    read: arvalid N+1, r handshake N+2, mem_ready N+3.
//    write: aw/w handshakes N+1, b handshake N+2, mem_ready N+3.
//  wstrb=0 write is still issued on AXI.
//  Reset mid-transaction: outputs clear immediately, no completion is emitted; the slave is reset together with the core.
// STRUCTURE
//  Add to friscv_h.sv: state encoding macros (3-bit), AXI_RESP_OKAY=2'b00, AXI_PROT_DEFAULT=3'b000.
//  Single module, no sub-module; one FSM always_ff plus registered request/response fields.
// TESTING
//  Read, zero-wait slave: addr 0x0040, rdata 0xDEADBEEF.
//    -> araddr=0x0040, mem_ready 3 cycles after accept, mem_rdata=0xDEADBEEF, mem_err=0.
//  Write, awready delayed 3 cycles, wready immediate: addr 0x0010, wdata 0x12345678, strb 4'b0011.
//    -> wvalid drops after 1 cycle, awvalid held 3, single bready handshake, mem_ready pulse.
//  Read with rresp=2'b10 (SLVERR).
//    -> mem_ready=1 and mem_err=1 same cycle, mem_err=0 next cycle.
//  mem_en held high over 3 alternating read/write requests.
//    -> exactly 3 AXI transactions in order, 3 mem_ready pulses, mem_addr changes while busy ignored.
//  aresetn asserted while in RD_DATA (rvalid pending).
//    -> arvalid/rready/mem_ready=0 immediately, state IDLE, no completion pulse.
//  srst pulse during WR_REQ with awvalid high.
//    -> next cycle all valids 0; a subsequent read completes normally.

Source files
------------

// File: rtl/friscv_rv32i_dbus_bridge_pkg.sv
// Shared encodings for the RV32I data-bus to AXI4-lite bridge:
// FSM states and the AXI response/protection constants the bridge emits or compares against.
package friscv_rv32i_dbus_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } dbus_state_t;

  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/friscv_rv32i_dbus_bridge.sv
// Bridges the ALU data-memory port to an AXI4-lite master with one transaction in flight;
// the request is latched on acceptance and completion is a single-cycle mem_ready pulse.
module friscv_rv32i_dbus_bridge
  import friscv_rv32i_dbus_bridge_pkg::*;
#(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               srst,
  input  logic               mem_en,
  input  logic               mem_wr,
  input  logic [ADDRW-1:0]   mem_addr,
  input  logic [XLEN-1:0]    mem_wdata,
  input  logic [XLEN/8-1:0]  mem_strb,
  output logic [XLEN-1:0]    mem_rdata,
  output logic               mem_ready,
  output logic               mem_err,
  output logic               awvalid,
  input  logic               awready,
  output logic [ADDRW-1:0]   awaddr,
  output logic [2:0]         awprot,
  output logic               wvalid,
  input  logic               wready,
  output logic [XLEN-1:0]    wdata,
  output logic [XLEN/8-1:0]  wstrb,
  input  logic               bvalid,
  output logic               bready,
  input  logic [1:0]         bresp,
  output logic               arvalid,
  input  logic               arready,
  output logic [ADDRW-1:0]   araddr,
  output logic [2:0]         arprot,
  input  logic               rvalid,
  output logic               rready,
  input  logic [XLEN-1:0]    rdata,
  input  logic [1:0]         rresp
);

  dbus_state_t             state;
  logic [ADDRW-1:0]        req_addr;
  logic [XLEN-1:0]         req_wdata;
  logic [XLEN/8-1:0]       req_strb;
  logic                    aw_done;
  logic                    w_done;

  // A write channel counts as finished once its valid has dropped or it handshakes this cycle.
  assign aw_done = ~awvalid | awready;
  assign w_done  = ~wvalid  | wready;

  assign awaddr = req_addr;
  assign araddr = req_addr;
  assign wdata  = req_wdata;
  assign wstrb  = req_strb;
  assign awprot = AXI_PROT_DEFAULT;
  assign arprot = AXI_PROT_DEFAULT;

  // NOTE: request fields carry no reset; they are only observed on AXI after being loaded at acceptance.
  always_ff @(posedge aclk) begin
    if (state == IDLE && mem_en) begin
      req_addr  <= mem_addr;
      req_wdata <= mem_wdata;
      req_strb  <= mem_strb;
    end
  end

  // NOTE: all state and registered outputs use <= so every branch sees pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else if (srst) begin
      state     <= IDLE;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en) begin
            if (mem_wr) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            mem_rdata <= rdata;
            mem_err   <= (rresp != AXI_RESP_OKAY);
            mem_ready <= 1'b1;
            state     <= DONE;
          end
        end
        WR_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            mem_err   <= (bresp != AXI_RESP_OKAY);
            mem_ready <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_friscv_rv32i_dbus_bridge.sv
// Directed bench for the data-bus bridge: a latency-programmable AXI4-lite slave model,
// a handshake monitor, and hand-computed expectations for each scenario.
module tb_friscv_rv32i_dbus_bridge;
  import friscv_rv32i_dbus_bridge_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        srst = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_wr = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_strb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready, mem_err;
  logic        awvalid, awready = 1'b0;
  logic [15:0] awaddr;
  logic [2:0]  awprot, arprot;
  logic        wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = 2'b00;
  logic        arvalid, arready = 1'b0;
  logic [15:0] araddr;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;

  friscv_rv32i_dbus_bridge #(.ADDRW(16), .XLEN(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave model: each ready/valid rises after <lat> cycles of the opposing signal being high.
  int          ar_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0, r_lat = 0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'b00;

  always @(negedge aclk) begin
    if (!aresetn || srst) begin
      arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (arvalid) begin arready = (ar_cnt >= ar_lat); ar_cnt++; end
      else begin arready = 1'b0; ar_cnt = 0; end
      if (awvalid) begin awready = (aw_cnt >= aw_lat); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_lat); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      if (bready) begin bvalid = (b_cnt >= b_lat); b_cnt++; end
      else begin bvalid = 1'b0; b_cnt = 0; end
      if (rready) begin rvalid = (r_cnt >= r_lat); r_cnt++; end
      else begin rvalid = 1'b0; r_cnt = 0; end
      rdata = s_rdata;
      rresp = s_rresp;
      bresp = 2'b00;
    end
  end

  // Monitor: logs address handshakes as {is_write, addr} and counts per-channel activity.
  logic [16:0] txn_log[$];
  int          aw_cycles = 0, w_cycles = 0, b_hs = 0, ready_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  always @(posedge aclk) begin
    if (aresetn) begin
      if (arvalid && arready) txn_log.push_back({1'b0, araddr});
      if (awvalid && awready) txn_log.push_back({1'b1, awaddr});
      if (wvalid && wready) begin last_wdata = wdata; last_wstrb = wstrb; end
      if (awvalid) aw_cycles++;
      if (wvalid) w_cycles++;
      if (bvalid && bready) b_hs++;
      if (mem_ready) ready_cnt++;
    end
  end

  task automatic clear_mon();
    txn_log.delete();
    aw_cycles = 0; w_cycles = 0; b_hs = 0; ready_cnt = 0;
  endtask

  task automatic start_req(input logic wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    mem_wr = wr; mem_addr = a; mem_wdata = d; mem_strb = s; mem_en = 1'b1;
  endtask

  task automatic wait_ready(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge aclk);
      cyc++;
    end while (!mem_ready && cyc < 20);
    check({tag, "_ready"}, 32'(mem_ready), 32'd1);
  endtask

  task automatic wait_issue();
    int k = 0;
    do begin
      @(negedge aclk);
      k++;
    end while (!(arvalid || awvalid) && k < 5);
  endtask

  initial begin
    int cyc;
    int saved;
    logic [16:0] exp_log [3];
    logic [15:0] addrs [3];
    logic        wrs [3];

    repeat (2) @(negedge aclk);
    check("rst_arvalid", 32'(arvalid), 0);
    check("rst_awvalid", 32'(awvalid), 0);
    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_bready", 32'(bready), 0);
    check("rst_rready", 32'(rready), 0);
    check("rst_mem_ready", 32'(mem_ready), 0);
    check("rst_mem_err", 32'(mem_err), 0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("prot", {26'd0, awprot, arprot}, 32'h0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Zero-wait read
    clear_mon();
    s_rdata = 32'hDEADBEEF;
    start_req(1'b0, 16'h0040, 32'h0, 4'h0);
    @(negedge aclk);
    check("t1_arvalid", 32'(arvalid), 1);
    check("t1_araddr", 32'(araddr), 32'h0040);
    wait_ready("t1", cyc);
    check("t1_latency", cyc + 1, 3);
    check("t1_rdata", mem_rdata, 32'hDEADBEEF);
    check("t1_err", 32'(mem_err), 0);
    mem_en = 1'b0;
    @(negedge aclk);
    check("t1_pulse_end", 32'(mem_ready), 0);
    check("t1_log_size", txn_log.size(), 1);
    check("t1_log0", 32'(txn_log[0]), 32'h00040);

    // Write with awready delayed, wready immediate
    clear_mon();
    aw_lat = 2;
    start_req(1'b1, 16'h0010, 32'h12345678, 4'b0011);
    wait_ready("t2", cyc);
    check("t2_latency", cyc, 5);
    check("t2_w_cycles", w_cycles, 1);
    check("t2_aw_cycles", aw_cycles, 3);
    check("t2_b_hs", b_hs, 1);
    check("t2_wdata", last_wdata, 32'h12345678);
    check("t2_wstrb", 32'(last_wstrb), 32'h3);
    check("t2_log0", 32'(txn_log[0]), 32'h10010);
    check("t2_err", 32'(mem_err), 0);
    check("t2_rdata_kept", mem_rdata, 32'hDEADBEEF);
    mem_en = 1'b0;
    aw_lat = 0;
    @(negedge aclk);

    // Read with SLVERR
    s_rresp = 2'b10;
    s_rdata = 32'hCAFEF00D;
    start_req(1'b0, 16'h0044, 32'h0, 4'h0);
    wait_ready("t3", cyc);
    check("t3_err", 32'(mem_err), 1);
    check("t3_rdata", mem_rdata, 32'hCAFEF00D);
    mem_en = 1'b0;
    @(negedge aclk);
    check("t3_ready_end", 32'(mem_ready), 0);
    check("t3_err_end", 32'(mem_err), 0);
    s_rresp = 2'b00;

    // Back-to-back requests with mem_en held high; core-side changes while busy ignored
    clear_mon();
    s_rdata = 32'h11112222;
    addrs = '{16'h0100, 16'h0104, 16'h0108};
    wrs   = '{1'b0, 1'b1, 1'b0};
    exp_log = '{17'h00100, 17'h10104, 17'h00108};
    for (int i = 0; i < 3; i++) begin
      start_req(wrs[i], addrs[i], 32'hA5A5A5A5, 4'hF);
      wait_issue();
      mem_addr = 16'hFFFC;
      mem_wr   = ~wrs[i];
      mem_wdata = 32'h0;
      wait_ready($sformatf("t4_%0d", i), cyc);
    end
    mem_en = 1'b0;
    repeat (2) @(negedge aclk);
    check("t4_ready_cnt", ready_cnt, 3);
    check("t4_log_size", txn_log.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t4_log%0d", i), 32'(txn_log[i]), 32'(exp_log[i]));
    check("t4_wdata", last_wdata, 32'hA5A5A5A5);

    // Asynchronous reset while read data is pending
    r_lat = 10;
    s_rdata = 32'h00000055;
    start_req(1'b0, 16'h0300, 32'h0, 4'h0);
    cyc = 0;
    do begin @(negedge aclk); cyc++; end while (!rready && cyc < 10);
    check("t5_in_rd_data", 32'(rready), 1);
    aresetn = 1'b0;
    mem_en  = 1'b0;
    #1;
    check("t5_arvalid", 32'(arvalid), 0);
    check("t5_rready", 32'(rready), 0);
    check("t5_mem_ready", 32'(mem_ready), 0);
    check("t5_state", 32'(dut.state), 32'(IDLE));
    check("t5_rdata_clr", mem_rdata, 32'h0);
    r_lat = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    saved = ready_cnt;
    repeat (4) @(negedge aclk);
    check("t5_no_completion", ready_cnt, saved);

    // Synchronous reset during WR_REQ, then a normal read
    aw_lat = 5;
    start_req(1'b1, 16'h0020, 32'h0F0F0F0F, 4'hF);
    @(negedge aclk);
    check("t6_awvalid", 32'(awvalid), 1);
    mem_en = 1'b0;
    srst   = 1'b1;
    @(negedge aclk);
    check("t6_valids", {29'd0, awvalid, wvalid, arvalid}, 32'h0);
    check("t6_mem_ready", 32'(mem_ready), 0);
    check("t6_state", 32'(dut.state), 32'(IDLE));
    srst   = 1'b0;
    aw_lat = 0;
    @(negedge aclk);
    s_rdata = 32'h0BADF00D;
    start_req(1'b0, 16'h0200, 32'h0, 4'h0);
    wait_ready("t6", cyc);
    check("t6_latency", cyc, 3);
    check("t6_rdata", mem_rdata, 32'h0BADF00D);
    check("t6_err", 32'(mem_err), 0);
    mem_en = 1'b0;
    @(negedge aclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_checks);
    $fatal(1);
  end

endmodule
